// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first.
// The difference and final borrow are published together when the DONE state is entered.
module sub_serial #(
  parameter int SZin = 8,
  parameter int N    = SZin + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SZin:0] in1,
  input  logic [SZin:0] in2,
  output logic          busy,
  output logic          done,
  output logic [SZin:0] res,
  output logic          borrow,
  output logic [1:0]    state_dbg
);

  // Handshake: start is a request that is accepted only in a cycle where busy=0 and done=0
  // (IDLE). The accepting edge captures in1/in2. done pulses for one cycle when res/borrow update.

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SZin:0] a_q, a_d;
  logic [SZin:0] b_q, b_d;
  logic [SZin:0] acc_q, acc_d;
  logic [SZin:0] res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bin_q, bin_d;
  logic          borrow_q, borrow_d;

  logic          bit_d;
  logic          bit_bout;
  logic          last_bit;

  assign bit_d    = a_q[0] ^ b_q[0] ^ bin_q;
  assign bit_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
  assign last_bit = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          acc_d   = '0;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // New bits enter at the MSB so bit 0 lands at the LSB after N shifts.
        acc_d = {bit_d, acc_q[SZin:1]};
        bin_d = bit_bout;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          res_d    = {bit_d, acc_q[SZin:1]};
          borrow_d = bit_bout;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign res       = res_q;
  assign borrow    = borrow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sub_serial.sv
// Directed and random checks of sub_serial with SZin=3 (4-bit operands, 4 bit-cycles).
module tb_sub_serial;

  localparam int SZIN = 3;
  localparam int N    = SZIN + 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [SZIN:0]   in1;
  logic [SZIN:0]   in2;
  logic            busy;
  logic            done;
  logic [SZIN:0]   res;
  logic            borrow;
  logic [1:0]      state_dbg;

  int vec_cnt;
  int err_cnt;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_res;
    logic       exp_borrow;
  } vec_t;

  vec_t vecs[10];

  logic [3:0] exp_q[$];

  sub_serial #(.SZin(SZIN), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .res       (res),
    .borrow    (borrow),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one operation from IDLE and follows it to the cycle after DONE.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] er, input logic eb, input string tag);
    logic [3:0] res_before;
    int         n;
    logic       seen;
    logic       run_ok;
    in1   = a;
    in2   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    in1   = ~a;
    in2   = a;
    res_before = res;
    n      = 0;
    seen   = 1'b0;
    run_ok = 1'b1;
    while (!seen && n < 20) begin
      if (!(busy === 1'b1 && done === 1'b0 && res === res_before)) run_ok = 1'b0;
      tick();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, " run_busy_hold"}, {31'd0, run_ok}, 32'd1);
    chk({tag, " latency"}, n, N);
    chk({tag, " res"}, {28'd0, res}, {28'd0, er});
    chk({tag, " borrow"}, {31'd0, borrow}, {31'd0, eb});
    chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, " idle_after"}, {30'd0, state_dbg, done}, 32'd0);
  endtask

  initial begin
    int         dn;
    int         last_cyc;
    int         cyc;
    int         idx;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] ops_a[3];
    logic [3:0] ops_b[3];

    vec_cnt = 0;
    err_cnt = 0;
    vecs[0] = '{4'd9,  4'd5,  4'd4,  1'b0};
    vecs[1] = '{4'd5,  4'd9,  4'd12, 1'b1};
    vecs[2] = '{4'd0,  4'd1,  4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 4'd0,  1'b0};
    vecs[4] = '{4'd3,  4'd0,  4'd3,  1'b0};
    vecs[5] = '{4'd0,  4'd15, 4'd1,  1'b1};
    vecs[6] = '{4'd8,  4'd7,  4'd1,  1'b0};
    vecs[7] = '{4'd7,  4'd8,  4'd15, 1'b1};
    vecs[8] = '{4'd10, 4'd3,  4'd7,  1'b0};
    vecs[9] = '{4'd6,  4'd6,  4'd0,  1'b0};

    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outputs", {28'd0, busy, done, borrow, 1'b0}, 32'd0);
    chk("reset_res", {28'd0, res}, 32'd0);
    chk("reset_state", {30'd0, state_dbg}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_borrow, $sformatf("vec%0d", i));
    end

    // start during RUN is ignored; only one done
    in1 = 4'd9; in2 = 4'd5; start = 1'b1;
    tick();
    in1 = 4'd1; in2 = 4'd2;
    dn = 0;
    for (int c = 0; c < 15; c++) begin
      start = (c < N - 1) ? 1'b1 : 1'b0;
      tick();
      if (done === 1'b1) dn++;
    end
    start = 1'b0;
    chk("ignore_start done_count", dn, 1);
    chk("ignore_start res", {28'd0, res}, 32'd4);

    // reset mid-run
    in1 = 4'd5; in2 = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst outputs", {28'd0, busy, done, borrow, 1'b0}, 32'd0);
    chk("midrst res", {28'd0, res}, 32'd0);
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done === 1'b1) dn++;
    end
    chk("midrst no_done", dn, 0);
    do_op(4'd12, 4'd4, 4'd8, 1'b0, "after_rst");

    // rst and start at the same edge
    in1 = 4'd1; in2 = 4'd2; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rst_wins busy", {31'd0, busy}, 32'd0);
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    chk("rst_wins no_activity", dn, 0);

    // back-to-back with start held high
    ops_a[0] = 4'd9; ops_b[0] = 4'd5;
    ops_a[1] = 4'd2; ops_b[1] = 4'd7;
    ops_a[2] = 4'd14; ops_b[2] = 4'd1;
    for (int j = 0; j < 3; j++) exp_q.push_back(ops_a[j] - ops_b[j]);
    idx = 0; cyc = 0; last_cyc = 0;
    in1 = ops_a[0]; in2 = ops_b[0]; start = 1'b1;
    while (idx < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (done === 1'b1) begin
        chk($sformatf("b2b res%0d", idx), {28'd0, res}, {28'd0, exp_q.pop_front()});
        if (idx > 0) chk($sformatf("b2b gap%0d", idx), cyc - last_cyc, N + 2);
        last_cyc = cyc;
        idx++;
        if (idx < 3) begin
          in1 = ops_a[idx]; in2 = ops_b[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b completed", idx, 3);
    tick();
    tick();

    // random operand pairs
    for (int r = 0; r < 32; r++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      do_op(ra, rb, ra - rb, (ra < rb), $sformatf("rnd%0d_%0d_%0d", r, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
